// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder exposing an 8-bit register file to an external master.
// A frame is an address byte (bit7 = read) followed by one data byte, MSB first.
// Local logic gets a registered read port and a write port. When a local write
// and an SPI commit hit the same register in the same cycle, the SPI write wins.
module spi_slave_regs #(
   parameter int REG_NUM     = 16,
   parameter int SYNC_STAGES = 2,
   localparam int AW         = $clog2(REG_NUM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          spi_cs,
   input  logic          spi_clk,
   input  logic          spi_mo,
   output logic          spi_mi,
   input  logic [AW-1:0] loc_rd_addr,
   output logic [7:0]    loc_rd_data,
   input  logic          loc_wr_en,
   input  logic [AW-1:0] loc_wr_addr,
   input  logic [7:0]    loc_wr_data,
   output logic          spi_wr_valid,
   output logic [6:0]    spi_wr_addr,
   output logic [7:0]    spi_wr_data,
   output logic          spi_rd_valid,
   output logic          spi_busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR  = 3'd1;
   localparam logic [2:0] WDATA = 3'd2;
   localparam logic [2:0] RDATA = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mo_sync_q;
   logic [SYNC_STAGES:0]   settle_q;
   logic                   cs_prev_q, sck_prev_q, armed_q;
   logic                   cs_s, sck_s, mo_s;
   logic                   cs_fall, cs_rise, sck_rise;

   logic [2:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] addr_q, addr_d;
   logic       mi_q, mi_d;
   logic       busy_q, busy_d;
   logic       wr_valid_q, wr_valid_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       rd_valid_q, rd_valid_d;

   logic [7:0] regs_q [REG_NUM];
   logic [7:0] shifted;
   logic       spi_we;

   assign cs_s  = cs_sync_q[SYNC_STAGES-1];
   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign mo_s  = mo_sync_q[SYNC_STAGES-1];

   // A CS fall only counts once CS has been seen high after reset, so a frame
   // already in progress at reset release is ignored.
   assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
   assign cs_rise  = ~cs_prev_q & cs_s;
   assign sck_rise = sck_s & ~sck_prev_q;
   assign shifted  = {rx_q[6:0], mo_s};

   // Synchronize SPI inputs and keep one cycle of history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q  <= '1;
         sck_sync_q <= '0;
         mo_sync_q  <= '0;
         settle_q   <= '0;
         cs_prev_q  <= 1'b1;
         sck_prev_q <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
         mo_sync_q  <= {mo_sync_q[SYNC_STAGES-2:0], spi_mo};
         settle_q   <= {settle_q[SYNC_STAGES-1:0], 1'b1};
         cs_prev_q  <= cs_s;
         sck_prev_q <= sck_s;
         armed_q    <= armed_q | (settle_q[SYNC_STAGES] & cs_s);
      end
   end

   // Frame FSM: decode the address, shift data in or out, and commit on the last bit.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      addr_d     = addr_q;
      mi_d       = mi_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_valid_d = 1'b0;
      spi_we     = 1'b0;
      if (cs_rise) begin
         state_d   = IDLE;
         mi_d      = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d   = ADDR;
                  bit_cnt_d = 3'd0;
                  busy_d    = 1'b1;
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  rx_d = shifted;
                  if (bit_cnt_q == 3'd7) begin
                     addr_d    = shifted;
                     bit_cnt_d = 3'd0;
                     if (shifted[7]) begin
                        // The read data is captured here, so later local
                        // writes cannot change the bits being shifted out.
                        state_d    = RDATA;
                        tx_d       = (32'(shifted[6:0]) < REG_NUM) ? regs_q[shifted[AW-1:0]] : 8'h00;
                        mi_d       = tx_d[7];
                        rd_valid_d = 1'b1;
                     end else begin
                        state_d = WDATA;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            WDATA: begin
               if (sck_rise) begin
                  rx_d = shifted;
                  if (bit_cnt_q == 3'd7) begin
                     spi_we     = (32'(addr_q[6:0]) < REG_NUM);
                     wr_valid_d = 1'b1;
                     wr_addr_d  = addr_q[6:0];
                     wr_data_d  = shifted;
                     state_d    = DONE;
                     bit_cnt_d  = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            RDATA: begin
               if (sck_rise) begin
                  tx_d = {tx_q[6:0], 1'b0};
                  mi_d = tx_q[6];
                  if (bit_cnt_q == 3'd6) begin
                     state_d   = DONE;
                     bit_cnt_d = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // FSM and output state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         rx_q       <= 8'h00;
         tx_q       <= 8'h00;
         addr_q     <= 8'h00;
         mi_q       <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 7'h00;
         wr_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         addr_q     <= addr_d;
         mi_q       <= mi_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Register file: SPI commit has priority over a local write to the same entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= 8'h00;
         loc_rd_data <= 8'h00;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (spi_we && (addr_q[AW-1:0] == AW'(i))) begin
               regs_q[i] <= shifted;
            end else if (loc_wr_en && (loc_wr_addr == AW'(i))) begin
               regs_q[i] <= loc_wr_data;
            end
         end
         loc_rd_data <= regs_q[loc_rd_addr];
      end
   end

   assign spi_mi       = mi_q;
   assign spi_busy     = busy_q;
   assign spi_wr_valid = wr_valid_q;
   assign spi_wr_addr  = wr_addr_q;
   assign spi_wr_data  = wr_data_q;
   assign spi_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: write/read frames, out-of-range access,
// aborted writes, local/SPI write collisions and reset in the middle of a frame.
module tb_spi_slave_regs;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          spi_cs, spi_clk, spi_mo, spi_mi;
   logic [AW-1:0] loc_rd_addr, loc_wr_addr;
   logic [7:0]    loc_rd_data, loc_wr_data;
   logic          loc_wr_en;
   logic          spi_wr_valid, spi_rd_valid, spi_busy;
   logic [6:0]    spi_wr_addr;
   logic [7:0]    spi_wr_data;

   int vec_cnt = 0;
   int err_cnt = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;
   logic [6:0] last_wa = '0;
   logic [7:0] last_wd = '0;

   spi_slave_regs #(.REG_NUM(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mo(spi_mo), .spi_mi(spi_mi),
      .loc_rd_addr(loc_rd_addr), .loc_rd_data(loc_rd_data),
      .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data),
      .spi_wr_valid(spi_wr_valid), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
      .spi_rd_valid(spi_rd_valid), .spi_busy(spi_busy)
   );

   always #5 clk = ~clk;

   // Count commit/decode pulses seen by the master side.
   always @(negedge clk) begin
      if (spi_wr_valid) begin
         wr_pulses <= wr_pulses + 1;
         last_wa   <= spi_wr_addr;
         last_wd   <= spi_wr_data;
      end
      if (spi_rd_valid) rd_pulses <= rd_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic loc_read(input logic [AW-1:0] a, output logic [7:0] d);
      @(negedge clk);
      loc_rd_addr = a;
      @(negedge clk);
      d = loc_rd_data;
   endtask

   task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      loc_wr_addr = a;
      loc_wr_data = d;
      loc_wr_en   = 1'b1;
      @(negedge clk);
      loc_wr_en   = 1'b0;
   endtask

   // Mode-0 master: drive MO with SCK low, rise, hold, sample MI, fall.
   // With hook set, loc_wr_en is pulsed exactly on the clk where the final
   // SCK rise commits (raw rise + 3 clk through the synchronizer/edge detect).
   task automatic spi_frame(input logic [7:0] a, input logic [7:0] d, input int nrise,
                            input bit raise_cs, input bit hook, output logic [7:0] rb);
      logic [15:0] bits;
      bits = {a, d};
      rb   = 8'h00;
      spi_cs = 1'b0;
      wait_clk(5);
      for (int i = 0; i < nrise; i++) begin
         spi_mo = bits[15-i];
         wait_clk(4);
         spi_clk = 1'b1;
         if (hook && i == 15) begin
            wait_clk(2);
            loc_wr_en = 1'b1;
            wait_clk(1);
            loc_wr_en = 1'b0;
            wait_clk(1);
         end else begin
            wait_clk(4);
         end
         if (i >= 7) rb = {rb[6:0], spi_mi};
         spi_clk = 1'b0;
      end
      wait_clk(4);
      if (raise_cs) begin
         spi_cs = 1'b1;
         wait_clk(5);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb, rd;
      int w0, r0;
      rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_mo = 1'b0;
      loc_rd_addr = '0; loc_wr_addr = '0; loc_wr_data = '0; loc_wr_en = 1'b0;
      wait_clk(3);
      chk("rst_mi", spi_mi, 0);
      chk("rst_busy", spi_busy, 0);
      chk("rst_wrv", spi_wr_valid, 0);
      chk("rst_rdv", spi_rd_valid, 0);
      chk("rst_locrd", loc_rd_data, 0);
      rst_n = 1'b1;
      wait_clk(6);

      // Write 0xA5 to register 3.
      w0 = wr_pulses;
      spi_cs = 1'b0;
      wait_clk(5);
      chk("busy_in_frame", spi_busy, 1);
      spi_frame(8'h03, 8'hA5, 16, 1, 0, rb);
      chk("wr_pulse", wr_pulses - w0, 1);
      chk("wr_addr", last_wa, 7'h03);
      chk("wr_data", last_wd, 8'hA5);
      chk("busy_after", spi_busy, 0);
      loc_read(4'd3, rd);
      chk("loc_reg3", rd, 8'hA5);

      // Read register 3 back over SPI.
      r0 = rd_pulses;
      spi_frame(8'h83, 8'h00, 15, 1, 0, rb);
      chk("rd_reg3", rb, 8'hA5);
      chk("rd_pulse", rd_pulses - r0, 1);
      chk("mi_after_cs", spi_mi, 0);

      // Out-of-range write/read; register 0 aliases addr 0x20 in its low bits.
      loc_write(4'd0, 8'h99);
      w0 = wr_pulses;
      spi_frame(8'h20, 8'h55, 16, 1, 0, rb);
      chk("oor_wr_pulse", wr_pulses - w0, 1);
      chk("oor_wr_addr", last_wa, 7'h20);
      chk("oor_wr_data", last_wd, 8'h55);
      loc_read(4'd0, rd);
      chk("oor_reg0", rd, 8'h99);
      r0 = rd_pulses;
      spi_frame(8'hA0, 8'h00, 15, 1, 0, rb);
      chk("oor_rd", rb, 8'h00);
      chk("oor_rd_pulse", rd_pulses - r0, 1);

      // Aborted write after 4 data bits leaves register 1 untouched.
      spi_frame(8'h01, 8'h11, 16, 1, 0, rb);
      w0 = wr_pulses;
      spi_frame(8'h01, 8'hF0, 12, 1, 0, rb);
      chk("abort_no_pulse", wr_pulses - w0, 0);
      loc_read(4'd1, rd);
      chk("abort_reg1", rd, 8'h11);
      spi_frame(8'h81, 8'h00, 15, 1, 0, rb);
      chk("abort_rd", rb, 8'h11);

      // Collision on register 2: SPI wins.
      loc_wr_addr = 4'd2; loc_wr_data = 8'h77;
      spi_frame(8'h02, 8'h3C, 16, 1, 1, rb);
      loc_read(4'd2, rd);
      chk("coll_reg2", rd, 8'h3C);
      // Local write to register 5 in the commit cycle of an SPI write to register 2.
      loc_write(4'd2, 8'h00);
      loc_wr_addr = 4'd5; loc_wr_data = 8'h77;
      spi_frame(8'h02, 8'h3C, 16, 1, 1, rb);
      loc_read(4'd5, rd);
      chk("coll_reg5", rd, 8'h77);
      loc_read(4'd2, rd);
      chk("coll_reg2_b", rd, 8'h3C);

      // Reset after 3 read data bits of a read of register 3.
      spi_frame(8'h83, 8'h00, 10, 0, 0, rb);
      chk("pre_rst_busy", spi_busy, 1);
      rst_n = 1'b0;
      wait_clk(1);
      chk("midrst_mi", spi_mi, 0);
      chk("midrst_busy", spi_busy, 0);
      wait_clk(2);
      rst_n = 1'b1;
      loc_read(4'd3, rd);
      chk("midrst_reg3", rd, 8'h00);
      loc_read(4'd1, rd);
      chk("midrst_reg1", rd, 8'h00);
      // CS still low at release: this frame must be ignored.
      w0 = wr_pulses;
      spi_frame(8'h03, 8'h66, 16, 1, 0, rb);
      chk("ign_pulse", wr_pulses - w0, 0);
      loc_read(4'd3, rd);
      chk("ign_reg3", rd, 8'h00);
      // Next frame behaves normally.
      w0 = wr_pulses;
      spi_frame(8'h04, 8'h5A, 16, 1, 0, rb);
      chk("post_wr_pulse", wr_pulses - w0, 1);
      spi_frame(8'h84, 8'h00, 15, 1, 0, rb);
      chk("post_rd", rb, 8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI mode-0 slave (responder) exposing a register file to an external SPI master. It is the far end of the team's SPI write/read master.
- Frame format: 8-bit address byte, MSB first. addr[7]=0 means write; addr[7]=1 means read.
- A write frame carries one data byte after the address. A read frame returns one byte on spi_mi, starting immediately after the last address bit (15 SCK rising edges per read frame, 16 per write frame).
- Local logic sees the register file through a registered read port and a local write port.

Parameters:
- REG_NUM, 16: number of 8-bit registers. Must be a power of 2, ≤64. Uses addr[AW-1:0], AW=log2(REG_NUM).
- SYNC_STAGES, 2: synchronizer depth on spi_cs/spi_clk/spi_mo.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- spi_cs  in  1  chip select, active low.
- spi_clk  in  1  SPI clock from master, idle low.
- spi_mo  in  1  master-out data.
- spi_mi  out  1  master-in data; driven low when not reading (no tristate).
- loc_rd_addr  in  AW  local read address.
- loc_rd_data  out  8  register contents, 1-cycle latency.
- loc_wr_en  in  1  local write strobe.
- loc_wr_addr  in  AW  local write address.
- loc_wr_data  in  8  local write data.
- spi_wr_valid  out  1  1-clk pulse when an SPI write commits.
- spi_wr_addr  out  7  address of committed write.
- spi_wr_data  out  8  data of committed write.
- spi_rd_valid  out  1  1-clk pulse when an SPI read address is decoded.
- spi_busy  out  1  high from CS-low detect to CS-high detect.

Behaviour:
- Reset (async, rst_n=0):
  - All registers = 0x00; state = IDLE.
  - spi_mi, loc_rd_data, spi_wr_valid, spi_wr_addr, spi_wr_data, spi_rd_valid, spi_busy all = 0.
- Input synchronization and edge detection:
  - spi_cs, spi_clk and spi_mo each pass through SYNC_STAGES flops; reset value of the cs chain is 1.
  - Edges are detected on the synchronized signals (previous vs current).
  - Requirement on the master: SCK high and low phases ≥4 clk each; CS setup before the first SCK rise ≥4 clk.
- FSM states: IDLE, ADDR, WDATA, RDATA, DONE. 3-bit bit_cnt; 8-bit rx_shift and tx_shift.
- IDLE:
  - On sync CS falling → ADDR, bit_cnt=0, spi_busy=1.
  - SCK edges are ignored.
- ADDR: each SCK rise shifts spi_mo into rx_shift LSB (MSB first overall). On the 8th rise:
  - Latch addr = {rx_shift[6:0], mo}.
  - If addr[7]=0 → WDATA.
  - If addr[7]=1 → RDATA. Load tx_shift with reg[addr[AW-1:0]], or 0x00 if addr[6:0] ≥ REG_NUM. Drive spi_mi = bit7 in the same clk. Pulse spi_rd_valid.
  - spi_mi must be valid within 1 clk of the edge detect, before the master samples at the following SCK fall.
- WDATA: 8 SCK rises shift in the data byte. On the 8th rise:
  - If addr[6:0] < REG_NUM, write reg[addr[AW-1:0]]. If out of range, no register changes.
  - In both cases pulse spi_wr_valid with spi_wr_addr=addr[6:0] and spi_wr_data=byte.
  - Go to DONE.
- RDATA:
  - Each subsequent SCK rise shifts tx_shift left; spi_mi = next bit.
  - After 7 further rises all 8 bits have been presented; go to DONE and hold spi_mi at bit0.
- DONE: SCK edges are ignored until CS rises.
- Sync CS rising in any state:
  - → IDLE; spi_mi=0; spi_busy=0; bit_cnt cleared.
  - A partial write is discarded: no register change, no spi_wr_valid.
  - Register contents are preserved.
- Local ports:
  - loc_rd_data <= reg[loc_rd_addr] every clk.
  - loc_wr_en writes reg[loc_wr_addr].
  - If an SPI commit and a local write target the same address in the same clk, the SPI write wins and the local write is dropped. Different addresses both commit.
  - A read of a register written in the same clk returns the old value.
- Read snapshot: the value returned over SPI is the one captured at address decode. Later local writes during the frame do not alter the bits being shifted out.
- Reset asserted mid-frame: immediate return to the reset state. A new frame requires a fresh CS falling edge after reset release; if CS is already low at release, that frame is ignored.
- Out-of-order events, e.g. a second CS fall while in IDLE without a preceding rise, cannot occur because edge detection is level-history based.

Test Plan:
- Write frame: CS low, send addr 0x03, then data 0xA5 (16 SCK) → one spi_wr_valid pulse with addr 0x03 / data 0xA5; loc_rd_addr=3 gives loc_rd_data=0xA5 one clk later.
- Read frame: send addr 0x83, 15 SCK total; the master samples spi_mi on each SCK fall starting at the 8th → sampled bits 1,0,1,0,0,1,0,1 (0xA5); spi_rd_valid pulses once; spi_mi=0 after CS high.
- Out-of-range (REG_NUM=16): write addr 0x20 data 0x55 → spi_wr_valid pulses, no register changes; read 0xA0 → returns 0x00.
- Abort: CS rises after 4 data bits of a write to 0x01 (prior value 0x11) → no spi_wr_valid; reg1 stays 0x11; the next full read of 0x81 returns 0x11.
- Collision: local write 0x77 to reg 2 in the same clk as an SPI commit of 0x3C to reg 2 → reg2=0x3C. Local write to reg 5 in that clk → reg5=0x77 as well.
- Reset mid-read: rst_n pulsed low after 3 read data bits → spi_mi=0, spi_busy=0, all registers 0x00; the following full frame behaves normally.
